reconf_dsp_seq: RTL
===================

Name: reconf_dsp_seq

Overview:
- Microcode sequencer that drives the exe_* control bus of one reconfigurable DSP element, or a cascade of elements sharing one control bus.
- Holds a small program RAM of control words and steps a program counter each cycle the element accepts a command (exe_ready=1).
- Runs the program as an optional prologue followed by a loop body for a programmed iteration count, or forever.
- Sits between the CSR/config fabric and the DSP element chain.

Parameters:
FIFO_PA_BITS, 5, width of the PA stack address field
FIFO_PD_BITS, 5, width of the PD stack address field
FIFO_PF_BITS, 5, width of the PC stack address field
CMD_WIDTH, 3, DSP command field width
PROG_BITS, 6, program RAM address width (depth 2^PROG_BITS)
ITER_WIDTH, 16, iteration counter width
IW, FIFO_PA_BITS+FIFO_PD_BITS+FIFO_PF_BITS+6+CMD_WIDTH, control word width (24 at defaults; derived, do not override)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
cfg_wr  in  1  program RAM write strobe
cfg_waddr  in  PROG_BITS  program RAM write address
cfg_wdata  in  IW  control word; fields from LSB: faa, fad, fac, pa_l, pd_l, pc_l, pi_r, pp_l, cmd, omux
cfg_last  in  PROG_BITS  address of the last loop-body word
cfg_loop  in  PROG_BITS  loop restart address (words below it form the prologue)
cfg_iters  in  ITER_WIDTH  loop count; 0 means run forever
cfg_start  in  1  start pulse
cfg_stop  in  1  graceful stop request
cfg_abort  in  1  immediate stop
exe_faa  out  FIFO_PA_BITS  PA stack address
exe_fad  out  FIFO_PD_BITS  PD stack address
exe_fac  out  FIFO_PF_BITS  PC stack address
exe_pa_l, exe_pd_l, exe_pc_l, exe_pi_r, exe_pp_l  out  1 each  load, consume and push flags
exe_cmd  out  CMD_WIDTH  DSP command
exe_cfg_omux  out  1  output mux select
exe_ready  in  1  element accepted the current word
busy  out  1  sequencer is in RUN
done  out  1  one-cycle pulse on return to IDLE after a completed run
iter_cnt  out  ITER_WIDTH  completed iterations of the current or last run
cfg_err  out  1  sticky flag: cfg_wr or cfg_start arrived while busy

Behaviour:
- States: IDLE and RUN. All registers are cleared asynchronously on rst_n=0: state=IDLE, pc=0, iter_cnt=0, stop_req=0, busy=0, done=0, cfg_err=0.
- Program RAM:
  - Asynchronous read at pc; synchronous write.
  - Writes are applied only in IDLE. A write in RUN is dropped and sets cfg_err.
- exe_* outputs:
  - Combinational from mem[pc] while in RUN.
  - In IDLE, all exe flags, exe_cmd and the addresses are forced to 0, and exe_cfg_omux is forced to 0.
- IDLE -> RUN: on cfg_start, load pc=0, iter_cnt=0, stop_req=0. busy is high the next cycle.
  - cfg_start in RUN is ignored and sets cfg_err.
  - cfg_start together with cfg_abort: abort wins and the block stays IDLE.
- RUN, exe_ready=0: hold pc and all outputs stable. No other state changes, except that stop_req still latches cfg_stop.
- RUN, exe_ready=1, pc != cfg_last: pc <= pc+1. Wrap modulo 2^PROG_BITS is permitted; keeping cfg_last reachable is software's responsibility.
- RUN, exe_ready=1, pc == cfg_last: iter_cnt <= iter_cnt+1, then:
  - If cfg_iters != 0 and iter_cnt+1 == cfg_iters: go to IDLE and pulse done.
  - Else if stop_req or cfg_stop: go to IDLE and pulse done.
  - Else: pc <= cfg_loop.
- iter_cnt saturates at all-ones in forever mode and holds its value in IDLE.
- cfg_stop in RUN sets stop_req, which is honoured only at an iteration boundary. cfg_stop in IDLE has no effect.
- cfg_abort in RUN: next cycle state=IDLE, pc=0, outputs zeroed, no done pulse, iter_cnt holds.
- The config inputs cfg_last, cfg_loop and cfg_iters are sampled live. Software must hold them stable during RUN.
- If cfg_loop > cfg_last, behaviour is undefined. The bench does not exercise it.
- Throughput: one control word per cycle when exe_ready is held at 1. Word-issue latency from cfg_start is 1 cycle.

Optional Feature:
RECONF_DSP_SEQ_STAT_EN
- Defined: adds output stall_cnt [31:0], a saturating count of RUN cycles with exe_ready=0. It clears on cfg_start and on reset.
- Undefined: no port and no counter logic.

Test Plan:
1. Load 4 words at addr 0-3, cfg_loop=1, cfg_last=3, cfg_iters=3, exe_ready=1 -> issue order 0,1,2,3,1,2,3,1,2,3; done 1 cycle after the 10th word; iter_cnt=3; busy low afterwards.
2. Same program with exe_ready low for 5 cycles at pc=2 -> exe_* hold the word at addr 2 unchanged for the whole stall; sequence otherwise identical; stall_cnt=5 when STAT_EN is defined.
3. cfg_iters=0, cfg_stop pulsed while pc=2 of iteration 4 -> finishes the iteration through addr 3, then IDLE with done; iter_cnt=4.
4. cfg_abort at pc=2 -> next cycle all exe_* are 0, busy=0, no done pulse, iter_cnt unchanged.
5. cfg_wr and cfg_start issued during RUN -> RAM contents unchanged, run unaffected, cfg_err=1 until reset.
6. rst_n asserted mid-run -> all outputs 0 immediately (asynchronous); after release, state is IDLE and a fresh cfg_start replays from addr 0.

Source files
------------

// File: rtl/reconf_dsp_seq.sv
// Microcode sequencer driving the exe_* control bus of a reconfigurable DSP element chain.
// Define RECONF_DSP_SEQ_STAT_EN to add the saturating stall_cnt output.
module reconf_dsp_seq #(
    parameter int FIFO_PA_BITS = 5,
    parameter int FIFO_PD_BITS = 5,
    parameter int FIFO_PF_BITS = 5,
    parameter int CMD_WIDTH    = 3,
    parameter int PROG_BITS    = 6,
    parameter int ITER_WIDTH   = 16,
    localparam int IW = FIFO_PA_BITS + FIFO_PD_BITS + FIFO_PF_BITS + 6 + CMD_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_wr,
    input  logic [PROG_BITS-1:0]    cfg_waddr,
    input  logic [IW-1:0]           cfg_wdata,
    input  logic [PROG_BITS-1:0]    cfg_last,
    input  logic [PROG_BITS-1:0]    cfg_loop,
    input  logic [ITER_WIDTH-1:0]   cfg_iters,
    input  logic                    cfg_start,
    input  logic                    cfg_stop,
    input  logic                    cfg_abort,
    output logic [FIFO_PA_BITS-1:0] exe_faa,
    output logic [FIFO_PD_BITS-1:0] exe_fad,
    output logic [FIFO_PF_BITS-1:0] exe_fac,
    output logic                    exe_pa_l,
    output logic                    exe_pd_l,
    output logic                    exe_pc_l,
    output logic                    exe_pi_r,
    output logic                    exe_pp_l,
    output logic [CMD_WIDTH-1:0]    exe_cmd,
    output logic                    exe_cfg_omux,
    input  logic                    exe_ready,
    output logic                    busy,
    output logic                    done,
    output logic [ITER_WIDTH-1:0]   iter_cnt,
`ifdef RECONF_DSP_SEQ_STAT_EN
    output logic [31:0]             stall_cnt,
`endif
    output logic                    cfg_err
);

    localparam int FAD_LSB  = FIFO_PA_BITS;
    localparam int FAC_LSB  = FAD_LSB + FIFO_PD_BITS;
    localparam int FLG_LSB  = FAC_LSB + FIFO_PF_BITS;
    localparam int CMD_LSB  = FLG_LSB + 5;
    localparam int OMUX_BIT = CMD_LSB + CMD_WIDTH;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state_q, state_d;
    logic [PROG_BITS-1:0]  pc_q, pc_d;
    logic [ITER_WIDTH-1:0] iter_q, iter_d, iter_inc;
    logic [ITER_WIDTH:0]   iter_plus1;
    logic                  stop_req_q, stop_req_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  last_iter;
    logic [IW-1:0]         word;

    // NOTE: the program RAM has no reset; its contents are owned by software.
    logic [IW-1:0] mem [2**PROG_BITS];

    always_ff @(posedge clk) begin
        if (cfg_wr && state_q == IDLE) begin
            mem[cfg_waddr] <= cfg_wdata;
        end
    end

    assign word = (state_q == RUN) ? mem[pc_q] : '0;

    assign exe_faa      = word[FAD_LSB-1:0];
    assign exe_fad      = word[FAC_LSB-1:FAD_LSB];
    assign exe_fac      = word[FLG_LSB-1:FAC_LSB];
    assign exe_pa_l     = word[FLG_LSB];
    assign exe_pd_l     = word[FLG_LSB+1];
    assign exe_pc_l     = word[FLG_LSB+2];
    assign exe_pi_r     = word[FLG_LSB+3];
    assign exe_pp_l     = word[FLG_LSB+4];
    assign exe_cmd      = word[OMUX_BIT-1:CMD_LSB];
    assign exe_cfg_omux = word[OMUX_BIT];

    assign busy     = (state_q == RUN);
    assign done     = done_q;
    assign iter_cnt = iter_q;
    assign cfg_err  = err_q;

    // The carry bit of iter_plus1 doubles as the saturation detect for forever mode.
    assign iter_plus1 = {1'b0, iter_q} + (ITER_WIDTH+1)'(1);
    assign iter_inc   = iter_plus1[ITER_WIDTH] ? iter_q : iter_plus1[ITER_WIDTH-1:0];
    assign last_iter  = (cfg_iters != '0) && (iter_plus1 == {1'b0, cfg_iters});

    // NOTE: every next-state variable gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        iter_d     = iter_q;
        stop_req_d = stop_req_q;
        done_d     = 1'b0;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (cfg_start && !cfg_abort) begin
                    state_d    = RUN;
                    pc_d       = '0;
                    iter_d     = '0;
                    stop_req_d = 1'b0;
                end
            end
            RUN: begin
                if (cfg_wr || cfg_start) begin
                    err_d = 1'b1;
                end
                if (cfg_abort) begin
                    state_d    = IDLE;
                    pc_d       = '0;
                    stop_req_d = 1'b0;
                end else begin
                    if (cfg_stop) begin
                        stop_req_d = 1'b1;
                    end
                    if (exe_ready) begin
                        if (pc_q != cfg_last) begin
                            pc_d = pc_q + PROG_BITS'(1);
                        end else begin
                            iter_d = iter_inc;
                            if (last_iter || stop_req_q || cfg_stop) begin
                                state_d    = IDLE;
                                pc_d       = '0;
                                stop_req_d = 1'b0;
                                done_d     = 1'b1;
                            end else begin
                                pc_d = cfg_loop;
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            iter_q     <= '0;
            stop_req_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            iter_q     <= iter_d;
            stop_req_q <= stop_req_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

`ifdef RECONF_DSP_SEQ_STAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (state_q == IDLE && cfg_start && !cfg_abort) begin
            stall_cnt <= '0;
        end else if (state_q == RUN && !exe_ready && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
